// File: rtl/fnd_scan_ctrl.sv
// N-digit common-anode FND scan controller with a snapshot ASCII serializer.
// The display path samples its inputs live every cycle; the serializer works
// from a shadow copy of i_bcd taken when a frame starts.
module fnd_scan_ctrl #(
  parameter int N_DIGITS = 4,
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] i_bcd,
  input  logic [N_DIGITS-1:0]   i_dot,
  input  logic [N_DIGITS-1:0]   i_blank,
  input  logic [N_DIGITS-1:0]   i_blink,
  input  logic                  i_lz_en,
  output logic [N_DIGITS-1:0]   fnd_com,
  output logic [7:0]            fnd_data,
  input  logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_busy
);

  // Serializer states
  //   state  | meaning
  //   S_IDLE | waiting for tx_start; no byte offered
  //   S_SEND | offering shadow digit chr_idx as ASCII, MSD first
  //   S_EOL  | offering the line feed that closes the frame

  localparam int SEL_W     = $clog2(N_DIGITS);
  localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int SCAN_CW   = $clog2(SCAN_DIV + 1);
  localparam int BLINK_CW  = $clog2(BLINK_DIV + 1);

  localparam logic [SCAN_CW-1:0]  SCAN_LAST  = SCAN_CW'(SCAN_DIV - 1);
  localparam logic [BLINK_CW-1:0] BLINK_LAST = BLINK_CW'(BLINK_DIV - 1);
  localparam logic [SEL_W-1:0]    SEL_LAST   = SEL_W'(N_DIGITS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_EOL  = 2'd2;

  logic [SCAN_CW-1:0]    scan_cnt;
  logic                  scan_tick;
  logic [SEL_W-1:0]      idx;
  logic [BLINK_CW-1:0]   blink_cnt;
  logic                  blink_phase;
  logic [N_DIGITS-1:0]   lz_mask;
  logic                  zero_above;
  logic [3:0]            cur_bcd;
  logic [6:0]            seg;
  logic [7:0]            data_nxt;
  logic [N_DIGITS-1:0]   com_nxt;

  logic [1:0]            state;
  logic [SEL_W-1:0]      chr_idx;
  logic [4*N_DIGITS-1:0] shadow;
  logic [3:0]            chr_bcd;
  logic                  hs;

  assign scan_tick = (scan_cnt == SCAN_LAST);
  assign hs        = tx_valid && tx_ready;

  // Scan divider and digit index; the index advances on the terminal count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_tick) begin
      scan_cnt <= '0;
      idx      <= (idx == SEL_LAST) ? '0 : idx + SEL_W'(1);
    end else begin
      scan_cnt <= scan_cnt + SCAN_CW'(1);
    end
  end

  // Blink phase toggles once per half blink period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BLINK_CW'(1);
    end
  end

  // Leading-zero mask: digit k (k>=1) is suppressed when it and everything above it is zero
  always_comb begin
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (i_bcd[4*k +: 4] == 4'd0);
      if (k != 0) lz_mask[k] = i_lz_en && zero_above;
    end
  end

  // Segment decode and priority for the digit currently being scanned
  always_comb begin
    cur_bcd = i_bcd[{idx, 2'b00} +: 4];
    case (cur_bcd)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
    com_nxt      = '1;
    com_nxt[idx] = 1'b0;
    if (i_blank[idx])                    data_nxt = 8'hFF;
    else if (blink_phase && i_blink[idx]) data_nxt = 8'hFF;
    else if (lz_mask[idx])               data_nxt = {~i_dot[idx], 7'h7F};
    else                                 data_nxt = {~i_dot[idx], seg};
  end

  // Registered FND pins, one cycle behind the scan index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fnd_com  <= '1;
      fnd_data <= 8'hFF;
    end else begin
      fnd_com  <= com_nxt;
      fnd_data <= data_nxt;
    end
  end

  // Serializer state, shadow capture and character index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      chr_idx <= '0;
      shadow  <= '0;
    end else begin
      case (state)
        S_IDLE: if (tx_start) begin
          shadow  <= i_bcd;
          chr_idx <= SEL_LAST;
          state   <= S_SEND;
        end
        S_SEND: if (hs) begin
          if (chr_idx == '0) state <= S_EOL;
          else               chr_idx <= chr_idx - SEL_W'(1);
        end
        S_EOL:   if (hs) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Byte presented to the UART path is a pure function of registered state
  always_comb begin
    chr_bcd  = shadow[{chr_idx, 2'b00} +: 4];
    tx_valid = 1'b0;
    tx_busy  = 1'b0;
    tx_data  = 8'h00;
    case (state)
      S_SEND: begin
        tx_valid = 1'b1;
        tx_busy  = 1'b1;
        tx_data  = (chr_bcd <= 4'd9) ? (8'h30 + {4'h0, chr_bcd}) : 8'h21;
      end
      S_EOL: begin
        tx_valid = 1'b1;
        tx_busy  = 1'b1;
        tx_data  = 8'h0A;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl: 4 digits, scan tick every 10 clk, blink phase every 50 clk.
module tb_fnd_scan_ctrl;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] i_bcd = '0;
  logic [3:0]  i_dot = '0, i_blank = '0, i_blink = '0;
  logic        i_lz_en = 1'b0;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_data;
  logic        tx_start = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        tx_busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  fnd_scan_ctrl #(.N_DIGITS(N), .CLK_HZ(1000), .SCAN_HZ(100), .BLINK_HZ(10)) dut (
    .clk(clk), .rst(rst), .i_bcd(i_bcd), .i_dot(i_dot), .i_blank(i_blank),
    .i_blink(i_blink), .i_lz_en(i_lz_en), .fnd_com(fnd_com), .fnd_data(fnd_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  // clock edges since reset release
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic get_digit(input int d, output logic [7:0] data, output bit ok);
    ok = 1'b0;
    data = 8'hxx;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk); #1;
      if (fnd_com[d] === 1'b0) begin ok = 1'b1; data = fnd_data; end
    end
  endtask

  task automatic start_frame(input logic [15:0] bcd, input logic [15:0] after);
    logic [3:0] nib;
    @(negedge clk);
    i_bcd = bcd;
    tx_start = 1'b1;
    for (int d = N - 1; d >= 0; d--) begin
      nib = bcd[4*d +: 4];
      exp_q.push_back((nib <= 4'd9) ? (8'h30 + {4'h0, nib}) : 8'h21);
    end
    exp_q.push_back(8'h0A);
    @(posedge clk); #1;
    tx_start = 1'b0;
    i_bcd = after;
  endtask

  task automatic drain(input logic [7:0] stall_byte, input int stall_n, input int poke_at,
                       output int iters);
    int stalls;
    logic [7:0] want;
    stalls = 0;
    iters = 0;
    while (exp_q.size() > 0 && iters < 60) begin
      @(negedge clk); #1;
      tx_start = (iters == poke_at);
      want = exp_q[0];
      total++;
      if (tx_valid !== 1'b1 || tx_busy !== 1'b1) begin
        bad++;
        $display("FAIL frame_flags: valid=%b busy=%b, want 1/1", tx_valid, tx_busy);
      end
      if (want == stall_byte && stalls < stall_n) begin
        tx_ready = 1'b0;
        stalls++;
        total++;
        if (tx_data !== want) begin
          bad++;
          $display("FAIL hold: tx_data=%h want %h", tx_data, want);
        end
      end else begin
        tx_ready = 1'b1;
        void'(exp_q.pop_front());
        total++;
        if (tx_data !== want) begin
          bad++;
          $display("FAIL byte: tx_data=%h want %h", tx_data, want);
        end
      end
      iters++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d bytes left, want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk); #1;
    tx_start = 1'b0;
    tx_ready = 1'b0;
    total++;
    if (tx_busy !== 1'b0 || tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle: busy=%b valid=%b, want 0/0", tx_busy, tx_valid);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (fnd_com !== 4'hF || fnd_data !== 8'hFF || tx_valid !== 1'b0 ||
        tx_data !== 8'h00 || tx_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset: com=%b data=%h valid=%b txd=%h busy=%b, want 1111 FF 0 00 0",
               fnd_com, fnd_data, tx_valid, tx_data, tx_busy);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_scan();
    logic [3:0] want;
    int ix;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      ix = ((cyc - 1) / 10) % 4;
      want = 4'b0001 << ix;
      want = ~want;
      total++;
      if (fnd_com !== want) begin
        bad++;
        $display("FAIL scan cyc%0d: com=%b want %b", cyc, fnd_com, want);
      end
    end
  endtask

  task automatic test_decode();
    logic [7:0] got;
    bit ok;
    logic [7:0] exp_a [4];
    logic [7:0] exp_b [4];
    exp_a = '{8'h99, 8'hB0, 8'h24, 8'hF9};
    exp_b = '{8'h99, 8'hFF, 8'h24, 8'hF9};
    i_bcd = 16'h1234;
    i_dot = 4'b0100;
    for (int d = 0; d < 4; d++) begin
      get_digit(d, got, ok);
      total++;
      if (!ok || got !== exp_a[d]) begin
        bad++;
        $display("FAIL decode d%0d: data=%h want %h", d, got, exp_a[d]);
      end
    end
    i_bcd = 16'h12C4;
    for (int d = 0; d < 4; d++) begin
      get_digit(d, got, ok);
      total++;
      if (!ok || got !== exp_b[d]) begin
        bad++;
        $display("FAIL decode_gt9 d%0d: data=%h want %h", d, got, exp_b[d]);
      end
    end
    i_dot = '0;
  endtask

  task automatic test_lz_blank();
    logic [7:0] got;
    bit ok;
    logic [15:0] t_bcd  [6];
    logic [3:0]  t_dot  [6];
    logic [3:0]  t_blk  [6];
    logic        t_lz   [6];
    logic [31:0] t_exp  [6];
    t_bcd = '{16'h0050, 16'h0050, 16'h0000, 16'h0000, 16'h0050, 16'h0050};
    t_dot = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0100};
    t_blk = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
    t_lz  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    t_exp = '{32'hFFFF92C0, 32'hFFFF92FF, 32'hFFFFFFC0, 32'h7FFFFFC0,
              32'hC0C092C0, 32'hFFFF92C0};
    for (int t = 0; t < 6; t++) begin
      i_bcd = t_bcd[t];
      i_dot = t_dot[t];
      i_blank = t_blk[t];
      i_lz_en = t_lz[t];
      for (int d = 0; d < 4; d++) begin
        get_digit(d, got, ok);
        total++;
        if (!ok || got !== t_exp[t][8*d +: 8]) begin
          bad++;
          $display("FAIL lz_blank t%0d d%0d: data=%h want %h", t, d, got, t_exp[t][8*d +: 8]);
        end
      end
    end
    i_dot = '0;
    i_blank = '0;
    i_lz_en = 1'b0;
  endtask

  task automatic test_blink();
    logic [7:0] want;
    int ph, seen0, seen1;
    seen0 = 0;
    seen1 = 0;
    i_bcd = 16'h0007;
    i_blink = 4'b0001;
    for (int i = 0; i < 240; i++) begin
      @(posedge clk); #1;
      ph = ((cyc - 1) / 50) % 2;
      if (fnd_com === 4'b1110) begin
        want = (ph == 1) ? 8'hFF : 8'hF8;
        if (ph == 1) seen1++; else seen0++;
      end else begin
        want = 8'hC0;
      end
      total++;
      if (fnd_data !== want) begin
        bad++;
        $display("FAIL blink cyc%0d com=%b: data=%h want %h", cyc, fnd_com, fnd_data, want);
      end
    end
    total++;
    if (seen0 == 0 || seen1 == 0) begin
      bad++;
      $display("FAIL blink_phases: on=%0d off=%0d, want both nonzero", seen0, seen1);
    end
    i_blink = '0;
  endtask

  task automatic test_backpressure();
    int it, ghost;
    start_frame(16'h1259, 16'h0000);
    drain(8'h35, 3, 1, it);
    ghost = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (tx_valid !== 1'b0 || tx_busy !== 1'b0) ghost++;
    end
    total++;
    if (ghost != 0) begin
      bad++;
      $display("FAIL start_ignored: %0d busy cycles after frame, want 0", ghost);
    end
  endtask

  task automatic test_back_to_back();
    int it;
    start_frame(16'h9A03, 16'h5555);
    drain(8'hFF, 0, -1, it);
    total++;
    if (it != N + 1) begin
      bad++;
      $display("FAIL b2b_cycles: %0d, want %0d", it, N + 1);
    end
  endtask

  task automatic test_reset_midframe();
    int it;
    logic [7:0] want;
    start_frame(16'h4321, 16'h9999);
    @(negedge clk); #1;
    tx_ready = 1'b1;
    want = exp_q.pop_front();
    total++;
    if (tx_data !== want) begin
      bad++;
      $display("FAIL rst_b1: tx_data=%h want %h", tx_data, want);
    end
    @(negedge clk); #1;
    tx_ready = 1'b0;
    total++;
    if (tx_data !== exp_q[0] || tx_valid !== 1'b1) begin
      bad++;
      $display("FAIL rst_b2: tx_data=%h valid=%b want %h 1", tx_data, tx_valid, exp_q[0]);
    end
    rst = 1'b0;
    #1;
    total++;
    if (tx_valid !== 1'b0 || tx_busy !== 1'b0 || tx_data !== 8'h00 ||
        fnd_com !== 4'hF || fnd_data !== 8'hFF) begin
      bad++;
      $display("FAIL async_rst: valid=%b busy=%b txd=%h com=%b data=%h, want 0 0 00 1111 FF",
               tx_valid, tx_busy, tx_data, fnd_com, fnd_data);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    start_frame(16'h8765, 16'h0000);
    drain(8'hFF, 0, -1, it);
    total++;
    if (it != N + 1) begin
      bad++;
      $display("FAIL rst_fresh_frame: %0d cycles, want %0d", it, N + 1);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_decode();
    test_lz_blank();
    test_blink();
    test_backpressure();
    test_back_to_back();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fnd_scan_ctrl.md
Name: fnd_scan_ctrl

Overview:
Parametrised N-digit seven-segment scan controller. It is the successor to the fixed 4-digit stopwatch FND driver. It multiplexes N_DIGITS BCD digits onto a common-anode FND with per-digit dot, blank, blink and leading-zero suppression. It also includes a snapshot ASCII serializer with valid/ready handshake that feeds the UART TX FIFO. It sits between the time/counter cores and the board FND pins and UART path.

Parameters:
N_DIGITS, 4, number of displayed digits; legal range 2..16.
CLK_HZ, 100_000_000, system clock frequency.
SCAN_HZ, 1000, per-digit scan tick rate.
BLINK_HZ, 2, blink frequency; one full on+off period per 1/BLINK_HZ s.
SEL_W, $clog2(N_DIGITS), localparam, scan index width.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
i_bcd  in  4*N_DIGITS  digit k at [4k+3:4k]; digit 0 is least significant
i_dot  in  N_DIGITS  1 = light dp of digit k
i_blank  in  N_DIGITS  1 = force digit k dark
i_blink  in  N_DIGITS  1 = digit k blinks
i_lz_en  in  1  1 = enable leading-zero suppression
fnd_com  out  N_DIGITS  active-low digit enable, one-hot-low
fnd_data  out  8  active-low segments; bit7 = dp
tx_start  in  1  pulse: snapshot i_bcd and send frame
tx_data  out  8  ASCII character
tx_valid  out  1  tx_data valid
tx_ready  in  1  sink accepts when high with tx_valid
tx_busy  out  1  frame in progress

Behaviour:
Reset (rst=0, async):
- fnd_com = all ones; fnd_data = 8'hFF.
- scan index = 0; divider counters = 0; blink phase = 0.
- serializer in IDLE; tx_valid = 0; tx_data = 8'h00; tx_busy = 0.
- A reset mid-frame abandons the frame; no partial resume.

Scan:
- Divider counts 0..CLK_HZ/SCAN_HZ-1 and emits a 1-cycle tick at the terminal count.
- On tick, the index increments; it wraps from N_DIGITS-1 to 0.
- fnd_com and fnd_data are registered, one cycle after the index update.
- fnd_com has bit idx low and all other bits high. Exactly one bit is low at all times after the first post-reset tick.

Segment encoding:
- BCD 0..9 map to C0,F9,A4,B0,99,92,82,F8,80,90.
- Any value >9 gives 7'h7F segments (dark).
- dp (bit7) = ~i_dot[idx] unless the digit is blanked.

Blink:
- Phase toggles every CLK_HZ/(2*BLINK_HZ) cycles.
- While phase=1, digits with i_blink set are dark.

Leading-zero suppression:
- Applies when i_lz_en=1, to digit k≥1 whose BCD is 0 and all of digits k+1..N_DIGITS-1 are 0.
- Such a digit shows segments dark but keeps its dp.
- Digit 0 is never suppressed.

Priority (highest first):
- i_blank: fnd_data = FF, dp dark.
- blink-off: fnd_data = FF.
- lz suppression.
- normal decode.
- Inputs are sampled live each cycle; no shadow on the display path.

Serializer FSM:
- IDLE:
  - tx_start=1 captures i_bcd into a shadow register and sets char index = N_DIGITS-1; next state SEND.
  - tx_busy = 0.
- SEND:
  - tx_valid = 1; tx_data = "0".."9" for shadow digit ≤9, else "!" (8'h21).
  - On tx_valid&&tx_ready: if index==0, go to EOL; else decrement index.
  - Without ready, tx_data and tx_valid hold.
- EOL:
  - tx_valid = 1; tx_data = 8'h0A.
  - On handshake, go to IDLE; tx_valid drops the next cycle.
- General serializer rules:
  - tx_busy = 1 in SEND and EOL.
  - tx_start is ignored while busy.
  - Changes to i_bcd after capture do not affect the frame.
  - The frame is N_DIGITS+1 bytes, most significant digit first.
  - At most one byte transfers per cycle; with back-to-back ready, a frame takes N_DIGITS+1 cycles.
  - Serializer and scan path are independent; both run concurrently.

Test Plan:
1. Reset/scan: N_DIGITS=4, CLK_HZ=1000, SCAN_HZ=100 (tick every 10 clk). Release reset → fnd_com cycles 1110,1101,1011,0111,1110, changing every 10 clk. During reset, fnd_com=1111 and fnd_data=FF.
2. Decode + dot: i_bcd=16'h1234, i_dot=4'b0100 → digit2 fnd_data=8'h24 (A4 with dp lit). Digit0 fnd_data=99. i_bcd digit1=4'hC → digit1 fnd_data=FF.
3. LZ/blank priority:
   - i_bcd=16'h0050, i_lz_en=1 → digits 3 and 2 FF; digit1 92; digit0 C0.
   - Set i_blank[0]=1 → digit0 FF.
   - i_bcd=0 → digit0 C0, others FF.
4. Blink: BLINK_HZ such that the phase toggles every 50 clk, i_blink=4'b0001, i_bcd=16'h0007.
   - Digit0 alternates F8 / FF on 50-clk boundaries.
   - Other digits are unaffected.
5. Serializer with backpressure: i_bcd=16'h1259, pulse tx_start, then change i_bcd to 0.
   - Bytes "1","2","5","9",0x0A are emitted.
   - tx_ready low for 3 cycles on byte "5" → tx_data holds 0x35.
   - tx_busy falls after 0x0A; a tx_start mid-frame is ignored.
6. Async reset mid-frame: assert rst low during byte 2.
   - Outputs go to reset values the same cycle, with no clock edge needed.
   - After release, a new tx_start sends a full fresh frame.
